// File: rtl/sopc_scope_sys_nios_oci_pkg.sv
// ============================================================================
//  Module      : sopc_scope_sys_nios_oci_pkg
//  Description : Shared constants, state encoding and trace symbol codes for
//                the OCI data-trace packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sopc_scope_sys_nios_oci_pkg;

    // Frame geometry
    localparam int SYMW   = 2;            // bits per trace symbol
    localparam int NSYM   = 15;           // symbols per frame
    localparam int CNTW   = 4;            // symbol count width, 2**CNTW > NSYM
    localparam int FRAMEW = SYMW * NSYM;  // frame payload width

    // End-of-test sequencing states
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        ENDING = 2'd2,
        ENDED  = 2'd3
    } dtrace_state_t;

    // Trace symbol encodings produced by the OCI trace logic
    localparam logic [SYMW-1:0] SYM_NOT_TAKEN = 2'b00;
    localparam logic [SYMW-1:0] SYM_TAKEN     = 2'b01;
    localparam logic [SYMW-1:0] SYM_EXCEPTION = 2'b10;
    localparam logic [SYMW-1:0] SYM_SYNC      = 2'b11;

endpackage

`default_nettype wire

// File: rtl/sopc_scope_sys_nios_oci_dtrace_packer_if.sv
// ============================================================================
//  Module      : sopc_scope_sys_nios_oci_dtrace_packer_if
//  Description : Symbol input, frame output and end-of-test signals of the
//                data-trace packer. drop_count exists only when
//                DTRACE_DROP_COUNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sopc_scope_sys_nios_oci_dtrace_packer_if;
    import sopc_scope_sys_nios_oci_pkg::*;

    logic              sym_valid;
    logic [SYMW-1:0]   sym_data;
    logic              sym_ready;
    logic              flush;
    logic              test_end_req;
    logic [FRAMEW-1:0] dct_buffer;
    logic [CNTW-1:0]   dct_count;
    logic              frame_valid;
    logic              frame_ready;
    logic              test_ending;
    logic              test_has_ended;
`ifdef DTRACE_DROP_COUNT_EN
    logic [15:0]       drop_count;
`endif

    // Packer side
    modport master (
        input  sym_valid, sym_data, flush, test_end_req, frame_ready,
        output sym_ready, dct_buffer, dct_count, frame_valid,
               test_ending, test_has_ended
`ifdef DTRACE_DROP_COUNT_EN
        , output drop_count
`endif
    );

    // Trace source / downstream side
    modport slave (
        output sym_valid, sym_data, flush, test_end_req, frame_ready,
        input  sym_ready, dct_buffer, dct_count, frame_valid,
               test_ending, test_has_ended
`ifdef DTRACE_DROP_COUNT_EN
        , input drop_count
`endif
    );

endinterface

`default_nettype wire

// File: rtl/sopc_scope_sys_nios_oci_dtrace_acc.sv
// ============================================================================
//  Module      : sopc_scope_sys_nios_oci_dtrace_acc
//  Description : Symbol accumulator. Writes symbols LSB-first into the next
//                free slot; a clear may coincide with a write, in which case
//                the new symbol lands in slot 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sopc_scope_sys_nios_oci_dtrace_acc
    import sopc_scope_sys_nios_oci_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              i_wr_en,
    input  wire logic [SYMW-1:0]   i_wr_data,
    input  wire logic              i_clear,
    output logic      [FRAMEW-1:0] o_acc,
    output logic      [CNTW-1:0]   o_cnt
);

    logic [FRAMEW-1:0] r_acc;
    logic [CNTW-1:0]   r_cnt;

    // Slot write / count with clear taking priority and restarting at slot 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
            if (i_wr_en) begin
                r_acc[SYMW-1:0] <= i_wr_data;
                r_cnt           <= CNTW'(1);
            end else begin
                r_cnt <= '0;
            end
        end else if (i_wr_en) begin
            for (int k = 0; k < NSYM; k++) begin
                if (r_cnt == CNTW'(k)) begin
                    r_acc[SYMW*k +: SYMW] <= i_wr_data;
                end
            end
            r_cnt <= r_cnt + CNTW'(1);
        end
    end

    assign o_acc = r_acc;
    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/sopc_scope_sys_nios_oci_dtrace_packer.sv
// ============================================================================
//  Module      : sopc_scope_sys_nios_oci_dtrace_packer
//  Description : Packs 2-bit trace symbols into 30-bit frames with a symbol
//                count, hands them downstream over valid/ready and sequences
//                end-of-test (drain, test_ending pulse, sticky test_has_ended).
//                Optional macro DTRACE_DROP_COUNT_EN: never backpressure the
//                trace source; discard overflow symbols and count them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sopc_scope_sys_nios_oci_dtrace_packer
    import sopc_scope_sys_nios_oci_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset_n,
    sopc_scope_sys_nios_oci_dtrace_packer_if.master bus
);

    dtrace_state_t     r_state;
    dtrace_state_t     w_state_nxt;
    logic [FRAMEW-1:0] r_dct_buffer;
    logic [CNTW-1:0]   r_dct_count;
    logic              r_frame_valid;
    logic              r_flush_pend;

    logic [FRAMEW-1:0] w_acc;
    logic [CNTW-1:0]   w_acc_cnt;
    logic              w_run;
    logic              w_out_free;
    logic              w_acc_full;
    logic              w_acc_nonempty;
    logic              w_stall;
    logic              w_sym_ready;
    logic              w_accept;
    logic              w_flush_run;
    logic              w_xfer;
    logic              w_test_ending;
    logic              w_test_has_ended;

    assign w_run          = (r_state == RUN);
    assign w_out_free     = !r_frame_valid | bus.frame_ready;
    assign w_acc_full     = (w_acc_cnt == CNTW'(NSYM));
    assign w_acc_nonempty = (w_acc_cnt != '0);
    assign w_stall        = w_acc_full & !w_out_free;
    assign w_flush_run    = bus.flush & w_run;

`ifdef DTRACE_DROP_COUNT_EN
    logic        w_drop;
    logic [15:0] r_drop_count;

    assign w_sym_ready = w_run;
    assign w_accept    = bus.sym_valid & w_run & !w_stall;
    assign w_drop      = bus.sym_valid & w_run & w_stall;

    // Saturating count of symbols discarded while both stages are full
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= '0;
        end else if (w_drop && r_drop_count != 16'hFFFF) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign bus.drop_count = r_drop_count;
`else
    assign w_sym_ready = w_run & !w_stall;
    assign w_accept    = bus.sym_valid & w_sym_ready;
`endif

    // A flush that coincides with an accept is deferred one cycle (via
    // r_flush_pend) so the accepted symbol travels in the flushed frame.
    assign w_xfer = w_out_free &
                    (w_acc_full |
                     ((((w_flush_run & !w_accept) | r_flush_pend)) & w_acc_nonempty) |
                     ((r_state == DRAIN) & w_acc_nonempty));

    sopc_scope_sys_nios_oci_dtrace_acc u_acc (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (w_accept),
        .i_wr_data (bus.sym_data),
        .i_clear   (w_xfer),
        .o_acc     (w_acc),
        .o_cnt     (w_acc_cnt)
    );

    // Remember a flush that could not transfer in its own cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_pend <= 1'b0;
        end else if (w_xfer) begin
            r_flush_pend <= w_flush_run & w_accept;
        end else if (w_flush_run && (w_acc_nonempty || w_accept)) begin
            r_flush_pend <= 1'b1;
        end
    end

    // Output register: load on transfer, drop when consumed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dct_buffer  <= '0;
            r_dct_count   <= '0;
            r_frame_valid <= 1'b0;
        end else if (w_xfer) begin
            r_dct_buffer  <= w_acc;
            r_dct_count   <= w_acc_cnt;
            r_frame_valid <= 1'b1;
        end else if (bus.frame_ready) begin
            r_frame_valid <= 1'b0;
        end
    end

    // End-of-test state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // End-of-test next state and status outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_test_ending    = 1'b0;
        w_test_has_ended = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.test_end_req) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!w_acc_nonempty && !r_frame_valid) begin
                    w_state_nxt = ENDING;
                end
            end
            ENDING: begin
                w_test_ending = 1'b1;
                w_state_nxt   = ENDED;
            end
            ENDED: begin
                w_test_has_ended = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign bus.sym_ready      = w_sym_ready;
    assign bus.dct_buffer     = r_dct_buffer;
    assign bus.dct_count      = r_dct_count;
    assign bus.frame_valid    = r_frame_valid;
    assign bus.test_ending    = w_test_ending;
    assign bus.test_has_ended = w_test_has_ended;

endmodule

`default_nettype wire

// File: tb/tb_sopc_scope_sys_nios_oci_dtrace_packer.sv
// ============================================================================
//  Module      : tb_sopc_scope_sys_nios_oci_dtrace_packer
//  Description : Scoreboard bench for the data-trace packer. Stimulus pushes
//                expected frames; a negedge monitor pops on each consumed
//                frame. Define DTRACE_DROP_COUNT_EN to exercise drop mode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sopc_scope_sys_nios_oci_dtrace_packer;

    typedef struct packed {
        logic [29:0] data;
        logic [3:0]  cnt;
    } frame_t;

    logic   clk;
    logic   reset_n;
    frame_t exp_q[$];
    int     checks;
    int     failures;

    sopc_scope_sys_nios_oci_dtrace_packer_if dif();

    sopc_scope_sys_nios_oci_dtrace_packer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [29:0] data, input logic [3:0] cnt);
        frame_t f;
        f.data = data;
        f.cnt  = cnt;
        exp_q.push_back(f);
    endtask

    // Offer one symbol and hold it until accepted (bounded)
    task automatic send(input logic [1:0] d);
        int n;
        n = 0;
        dif.sym_valid = 1'b1;
        dif.sym_data  = d;
        @(negedge clk);
        while (!dif.sym_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        dif.sym_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        dif.flush = 1'b1;
        @(posedge clk); #1;
        dif.flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one pop per consumed frame
    always @(negedge clk) begin
        if (reset_n && dif.frame_valid && dif.frame_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", {dif.dct_buffer, 2'b00}, 32'hFFFF_FFFF);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                chk("frame_data", {2'b00, dif.dct_buffer}, {2'b00, f.data});
                chk("frame_count", {28'd0, dif.dct_count}, {28'd0, f.cnt});
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        dif.sym_valid    = 1'b0;
        dif.sym_data     = 2'b00;
        dif.flush        = 1'b0;
        dif.test_end_req = 1'b0;
        dif.frame_ready  = 1'b1;
        #3;
        chk("rst_buffer", {2'b00, dif.dct_buffer}, 32'd0);
        chk("rst_count", {28'd0, dif.dct_count}, 32'd0);
        chk("rst_valid", {31'd0, dif.frame_valid}, 32'd0);
        chk("rst_ending", {31'd0, dif.test_ending}, 32'd0);
        chk("rst_ended", {31'd0, dif.test_has_ended}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(2);

        // T1: 15 symbols 0,1,2,3,... then a 16th taken in the transfer cycle
        push_frame(30'h24E4E4E4, 4'd15);
        for (int i = 0; i < 15; i++) send(2'(i % 4));
        dif.sym_valid = 1'b1;
        dif.sym_data  = 2'd3;
        @(negedge clk);
        chk("t1_ready_16th", {31'd0, dif.sym_ready}, 32'd1);
        chk("t1_valid_before", {31'd0, dif.frame_valid}, 32'd0);
        @(posedge clk); #1;
        dif.sym_valid = 1'b0;
        chk("t1_valid_after", {31'd0, dif.frame_valid}, 32'd1);
        push_frame(30'h3, 4'd1);
        pulse_flush();
        idle(2);
        push_frame(30'h39393939, 4'd15);
        for (int i = 0; i < 15; i++) send(2'((i + 1) % 4));
        idle(3);

        // T2: 5 taken symbols then flush; flush of an empty accumulator
        push_frame(30'h155, 4'd5);
        for (int i = 0; i < 5; i++) send(2'b01);
        pulse_flush();
        idle(3);
        pulse_flush();
        idle(3);
        @(negedge clk);
        chk("t2_empty_flush", {31'd0, dif.frame_valid}, 32'd0);
        @(posedge clk); #1;

`ifndef DTRACE_DROP_COUNT_EN
        // T3: backpressure with 31 symbols offered
        dif.frame_ready = 1'b0;
        push_frame(30'h2AAAAAAA, 4'd15);
        push_frame(30'h3FFFFFFF, 4'd15);
        push_frame(30'h1, 4'd1);
        for (int i = 0; i < 15; i++) send(2'b10);
        for (int i = 0; i < 15; i++) send(2'b11);
        dif.sym_valid = 1'b1;
        dif.sym_data  = 2'b01;
        repeat (3) begin
            @(negedge clk);
            chk("t3_ready_low", {31'd0, dif.sym_ready}, 32'd0);
        end
        @(posedge clk); #1;
        dif.frame_ready = 1'b1;
        @(negedge clk);
        chk("t3_ready_release", {31'd0, dif.sym_ready}, 32'd1);
        @(posedge clk); #1;
        dif.sym_valid = 1'b0;
        pulse_flush();
        idle(3);
`endif

        // T4: asynchronous reset with a frame held and 7 symbols in flight
        dif.frame_ready = 1'b0;
        for (int i = 0; i < 15; i++) send(2'b00);
        for (int i = 0; i < 7; i++) send(2'b11);
        @(negedge clk);
        chk("t4_held", {31'd0, dif.frame_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t4_rst_valid", {31'd0, dif.frame_valid}, 32'd0);
        chk("t4_rst_buffer", {2'b00, dif.dct_buffer}, 32'd0);
        chk("t4_rst_count", {28'd0, dif.dct_count}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        dif.frame_ready = 1'b1;
        push_frame(30'h1B, 4'd3);
        send(2'b11);
        send(2'b10);
        send(2'b01);
        pulse_flush();
        idle(3);

        // T5: end-of-test sequence
        push_frame(30'h15, 4'd3);
        for (int i = 0; i < 3; i++) send(2'b01);
        dif.test_end_req = 1'b1;
        @(posedge clk); #1;
        dif.test_end_req = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (dif.test_ending) begin
                pulses++;
                chk("t5_drained_first", 32'(exp_q.size()), 32'd0);
            end
        end
        chk("t5_pulse_count", 32'(pulses), 32'd1);
        chk("t5_has_ended", {31'd0, dif.test_has_ended}, 32'd1);
        @(posedge clk); #1;
        dif.sym_valid    = 1'b1;
        dif.sym_data     = 2'b11;
        dif.flush        = 1'b1;
        dif.test_end_req = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t5_ready_off", {31'd0, dif.sym_ready}, 32'd0);
            chk("t5_no_frame", {31'd0, dif.frame_valid}, 32'd0);
            chk("t5_sticky", {30'd0, dif.test_has_ended, dif.test_ending}, 32'd2);
        end
        @(posedge clk); #1;
        dif.sym_valid    = 1'b0;
        dif.flush        = 1'b0;
        dif.test_end_req = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        chk("t5_reset_exit", {30'd0, dif.test_has_ended, dif.sym_ready}, 32'd1);
        idle(1);

`ifdef DTRACE_DROP_COUNT_EN
        // T6: overflow drops with no backpressure
        dif.frame_ready = 1'b0;
        push_frame(30'h0, 4'd15);
        push_frame(30'h2AAAAAAA, 4'd15);
        for (int i = 0; i < 40; i++) begin
            dif.sym_valid = 1'b1;
            dif.sym_data  = (i < 15) ? 2'b00 : ((i < 30) ? 2'b10 : 2'b01);
            @(negedge clk);
            chk("t6_ready_high", {31'd0, dif.sym_ready}, 32'd1);
            @(posedge clk); #1;
        end
        dif.sym_valid = 1'b0;
        chk("t6_drop_count", {16'd0, dif.drop_count}, 32'd10);
        dif.frame_ready = 1'b1;
        idle(4);
        chk("t6_drop_hold", {16'd0, dif.drop_count}, 32'd10);
        chk("t6_empty", {31'd0, dif.frame_valid}, 32'd0);
`endif

        idle(3);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
